// File: rtl/fifo_modport_if.sv
// rtl/fifo_modport_if.sv - write/read handshake bundle for the single-clock FIFO
interface fifo_modport_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;

    // Producer/consumer side of the bundle.
    modport master (
        output winc,
        output wdata,
        output rinc,
        input  wfull,
        input  rdata,
        input  rempty
    );

    // FIFO side of the bundle.
    modport slave (
        input  winc,
        input  wdata,
        input  rinc,
        output wfull,
        output rdata,
        output rempty
    );
endinterface

// File: rtl/fifo_modport.sv
// rtl/fifo_modport.sv - single-clock FIFO with registered read data and pointer-derived flags
module fifo_modport #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic           clk,
    input  logic           rst,
    fifo_modport_if.slave  bus
);
    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [0:DEPTH-1];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [DSIZE-1:0] rdata_q;
    logic             full;
    logic             empty;
    logic             write_en;
    logic             read_en;

    // The extra MSB on each pointer separates "same slot, empty" from "same slot, full".
    assign empty = (wptr == rptr);
    assign full  = (wptr[ASIZE] != rptr[ASIZE]) &&
                   (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);

    assign write_en = bus.winc && !full;
    assign read_en  = bus.rinc && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            rdata_q <= '0;
        end else begin
            if (write_en) begin
                wptr <= wptr + 1'b1;
            end
            if (read_en) begin
                rdata_q <= mem[rptr[ASIZE-1:0]];
                rptr    <= rptr + 1'b1;
            end
        end
    end

    // Storage is never cleared; a write during reset must not land.
    always_ff @(posedge clk) begin
        if (!rst && write_en) begin
            mem[wptr[ASIZE-1:0]] <= bus.wdata;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.wfull  = full;
    assign bus.rempty = empty;
endmodule

// File: tb/tb_fifo_modport.sv
// tb/tb_fifo_modport.sv - directed self-checking bench for fifo_modport
module tb_fifo_modport;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fifo_modport_if #(.DSIZE(8), .ASIZE(4)) bus ();

    fifo_modport #(.DSIZE(8), .ASIZE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.winc  = 1'b1;
        bus.wdata = d;
        tick();
        bus.winc  = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] exp);
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        check(tag, {8'h00, bus.rdata}, {8'h00, exp});
    endtask

    initial begin
        bus.winc  = 1'b1;
        bus.rinc  = 1'b1;
        bus.wdata = 8'h77;
        rst       = 1'b1;

        // Reset held two cycles with both requests asserted.
        tick();
        tick();
        rst      = 1'b0;
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        check("rst_rempty", {15'd0, bus.rempty}, 16'd1);
        check("rst_wfull",  {15'd0, bus.wfull},  16'd0);
        check("rst_rdata",  {8'h00, bus.rdata},  16'h0000);
        tick();
        check("rst_idle_rempty", {15'd0, bus.rempty}, 16'd1);

        // Single word.
        wr(8'hA5);
        check("single_rempty_low", {15'd0, bus.rempty}, 16'd0);
        rd_expect("single_rdata", 8'hA5);
        check("single_rempty_high", {15'd0, bus.rempty}, 16'd1);

        // Fill, overflow attempt, drain.
        for (int i = 0; i < 16; i++) begin
            wr(8'(i));
            check($sformatf("fill_wfull_%0d", i), {15'd0, bus.wfull}, (i == 15) ? 16'd1 : 16'd0);
        end
        wr(8'hFF);
        check("ovf_wfull", {15'd0, bus.wfull}, 16'd1);
        for (int i = 0; i < 16; i++) begin
            rd_expect($sformatf("drain_%0d", i), 8'(i));
            if (i == 0)
                check("drain_wfull_clear", {15'd0, bus.wfull}, 16'd0);
        end
        check("drain_rempty", {15'd0, bus.rempty}, 16'd1);

        // Underflow: reads on empty change nothing.
        for (int i = 0; i < 3; i++) begin
            rd_expect($sformatf("unf_rdata_%0d", i), 8'h0F);
            check($sformatf("unf_rempty_%0d", i), {15'd0, bus.rempty}, 16'd1);
        end
        wr(8'h55);
        rd_expect("unf_ptr_intact", 8'h55);
        check("unf_ptr_rempty", {15'd0, bus.rempty}, 16'd1);

        // Streaming with 5 words resident, crosses the address wrap.
        for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
        bus.winc = 1'b1;
        bus.rinc = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.wdata = 8'(8'h15 + k);
            tick();
            check($sformatf("sim_rdata_%0d", k), {8'h00, bus.rdata}, 16'(8'h10 + k));
            check($sformatf("sim_flags_%0d", k), {14'd0, bus.wfull, bus.rempty}, 16'd0);
        end
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        for (int i = 0; i < 5; i++) rd_expect($sformatf("sim_tail_%0d", i), 8'(8'h24 + i));
        check("sim_tail_rempty", {15'd0, bus.rempty}, 16'd1);

        // Both asserted while full: read wins, write dropped.
        for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
        check("full_before", {15'd0, bus.wfull}, 16'd1);
        bus.winc  = 1'b1;
        bus.rinc  = 1'b1;
        bus.wdata = 8'hEE;
        tick();
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        check("full_both_wfull", {15'd0, bus.wfull}, 16'd0);
        check("full_both_rdata", {8'h00, bus.rdata}, 16'h0040);
        for (int i = 1; i < 16; i++) rd_expect($sformatf("full_drain_%0d", i), 8'(8'h40 + i));
        check("full_drain_rempty", {15'd0, bus.rempty}, 16'd1);

        // Both asserted while empty: write wins, rdata held.
        bus.winc  = 1'b1;
        bus.rinc  = 1'b1;
        bus.wdata = 8'h99;
        tick();
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        check("empty_both_rempty", {15'd0, bus.rempty}, 16'd0);
        check("empty_both_rdata",  {8'h00, bus.rdata},  16'h004F);
        rd_expect("empty_both_word", 8'h99);
        check("empty_both_occ1", {15'd0, bus.rempty}, 16'd1);

        // Reset with 8 words stored.
        for (int i = 0; i < 8; i++) wr(8'(8'h60 + i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rempty", {15'd0, bus.rempty}, 16'd1);
        check("mid_rst_wfull",  {15'd0, bus.wfull},  16'd0);
        check("mid_rst_rdata",  {8'h00, bus.rdata},  16'h0000);
        wr(8'h3C);
        rd_expect("mid_rst_word", 8'h3C);
        check("mid_rst_final_rempty", {15'd0, bus.rempty}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
